// File: rtl/ice51_pkg.sv
// ice51_pkg: shared defaults and the loader state encoding for the ice51
// boot path. Used by the loader, its UART deserialiser, ice51_top and the bench.
// Optional checksum stage in the loader is enabled by ICE51_LOADER_CHECKSUM_EN.
package ice51_pkg;

    // 12 MHz / 115200 baud
    localparam int BAUD_DIV_DEFAULT = 104;
    // Image size in bytes
    localparam int MEM_SIZE_DEFAULT = 1024;
    // Code memory address width; MEM_SIZE must fit in 2**ADDR_W
    localparam int ADDR_W_DEFAULT   = 10;

    // Depth of the RX input synchroniser
    localparam int SYNC_STAGES = 2;

    // IDLE/START/DATA/STOP are used by the deserialiser. The loader reuses
    // IDLE as "loading image bytes", plus CSUM, DONE and ERR.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        CSUM  = 3'd5,
        ERR   = 3'd6
    } loader_state_t;

    // Running image checksum: plain 8-bit sum, wrapping mod 256
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/ice51_loader_if.sv
// ice51_loader_if: code-memory write port between the boot loader (master)
// and the ice51 code memory (slave).
interface ice51_loader_if #(
    parameter int ADDR_W = 10
);
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;

    modport master (
        output o_mem_we,
        output o_mem_addr,
        output o_mem_wdata
    );

    modport slave (
        input o_mem_we,
        input o_mem_addr,
        input o_mem_wdata
    );
endinterface

// File: rtl/ice51_uart_rx.sv
// ice51_uart_rx: 8N1 UART receiver, LSB first. Synchronises the raw RX pin,
// finds the start bit, samples mid-bit and reports each byte with a one-cycle
// valid pulse (good stop bit) or frame_err pulse (bad stop bit), both in the
// cycle after the stop-bit sample. Deasserting i_en parks it in IDLE.
module ice51_uart_rx
    import ice51_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_en,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int                CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic                   w_rx;

    loader_state_t    r_state, w_state_next;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_next;
    logic [2:0]       r_bit_idx, w_bit_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_valid, w_valid_next;
    logic             r_frame_err, w_frame_err_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First synchroniser flop, idles high like the line
                always_ff @(posedge i_clk) begin
                    if (!i_nrst) r_rx_sync[gi] <= 1'b1;
                    else         r_rx_sync[gi] <= i_rx;
                end
            end else begin : g_rest
                // Remaining synchroniser flops
                always_ff @(posedge i_clk) begin
                    if (!i_nrst) r_rx_sync[gi] <= 1'b1;
                    else         r_rx_sync[gi] <= r_rx_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_rx = r_rx_sync[SYNC_STAGES-1];

    // Deserialiser state, counters and registered result pulses
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_baud_cnt  <= w_baud_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_byte      <= w_byte_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Next-state: start detect, mid-bit sampling, stop-bit check
    always_comb begin
        w_state_next     = r_state;
        w_baud_cnt_next  = r_baud_cnt + 1'b1;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_byte_next      = r_byte;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_cnt_next = '0;
                if (!w_rx) w_state_next = START;
            end
            START: begin
                // Re-check at mid start bit; a short low pulse is a glitch
                if (r_baud_cnt == CNT_HALF) begin
                    w_baud_cnt_next = '0;
                    if (!w_rx) begin
                        w_state_next   = DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_baud_cnt_next = '0;
                    w_shift_next    = {w_rx, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) w_state_next = STOP;
                    else                   w_bit_idx_next = r_bit_idx + 3'd1;
                end
            end
            STOP: begin
                // Straight back to IDLE so a following start edge is caught
                if (r_baud_cnt == CNT_LAST) begin
                    w_baud_cnt_next = '0;
                    w_state_next    = IDLE;
                    if (w_rx) begin
                        w_valid_next = 1'b1;
                        w_byte_next  = r_shift;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_baud_cnt_next = '0;
            end
        endcase

        if (!i_en) begin
            w_state_next     = IDLE;
            w_baud_cnt_next  = '0;
            w_valid_next     = 1'b0;
            w_frame_err_next = 1'b0;
        end
    end

    assign o_byte      = r_byte;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ice51_loader.sv
// ice51_loader: UART boot loader. Receives MEM_SIZE bytes and writes them to
// code memory from address 0 upward while holding the core in reset, then
// releases the core. With ICE51_LOADER_CHECKSUM_EN defined, one extra byte
// must match the 8-bit sum of the image before release; a mismatch or a
// framing error on it latches o_load_err until reset.
module ice51_loader
    import ice51_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  logic           i_uart_rx,
    ice51_loader_if.master mem_if,
    output logic           o_cpu_nrst,
    output logic           o_frame_err,
    output logic           o_load_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    loader_state_t     r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic              w_rx_en;
    logic              w_receiving;
    logic [7:0]        w_rx_byte;
    logic              w_rx_valid;
    logic              w_rx_frame_err;
    logic              w_we;

`ifdef ICE51_LOADER_CHECKSUM_EN
    logic [7:0]        r_sum, w_sum_next;
`endif

    // RX keeps running only while bytes are still wanted
    assign w_receiving = (r_state == IDLE) || (r_state == CSUM);
    assign w_rx_en     = w_receiving;

    ice51_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_en        (w_rx_en),
        .i_rx        (i_uart_rx),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_frame_err)
    );

    // Loader state, write address and running checksum
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= IDLE;
            r_addr  <= '0;
`ifdef ICE51_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
`ifdef ICE51_LOADER_CHECKSUM_EN
            r_sum   <= w_sum_next;
`endif
        end
    end

    // Next-state: write each image byte, advance address, decide release
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_we         = 1'b0;
`ifdef ICE51_LOADER_CHECKSUM_EN
        w_sum_next   = r_sum;
`endif

        case (r_state)
            IDLE: begin
                if (w_rx_valid) begin
                    w_we = 1'b1;
`ifdef ICE51_LOADER_CHECKSUM_EN
                    w_sum_next = csum_add(r_sum, w_rx_byte);
`endif
                    // Address stays on the last location: no wrap-around
                    if (r_addr == LAST_ADDR) begin
`ifdef ICE51_LOADER_CHECKSUM_EN
                        w_state_next = CSUM;
`else
                        w_state_next = DONE;
`endif
                    end else begin
                        w_addr_next = r_addr + 1'b1;
                    end
                end
            end
`ifdef ICE51_LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_rx_frame_err) begin
                    w_state_next = ERR;
                end else if (w_rx_valid) begin
                    w_state_next = (w_rx_byte == r_sum) ? DONE : ERR;
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
`endif
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // Write strobe and data come straight from registered RX results, so the
    // write lands one cycle after the stop-bit sample
    assign mem_if.o_mem_we    = w_we;
    assign mem_if.o_mem_addr  = r_addr;
    assign mem_if.o_mem_wdata = w_rx_byte;

    assign o_cpu_nrst  = (r_state == DONE);
    assign o_frame_err = w_rx_frame_err && w_receiving;

`ifdef ICE51_LOADER_CHECKSUM_EN
    assign o_load_err = (r_state == ERR);
`else
    assign o_load_err = 1'b0;
`endif

endmodule
